// File: rtl/nios_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
// The state encoding and the sysid slave word offsets live here.
package nios_sysid_pkg;

   localparam int unsigned SYSID_DATA_W    = 32;
   localparam logic        SYSID_ID_OFFSET = 1'b0;
   localparam logic        SYSID_TS_OFFSET = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      FIN
   } sysid_state_t;

endpackage

// File: rtl/nios_sysid_read_engine.sv
// Performs one Avalon-MM read at a time: it holds the request under waitrequest,
// waits out the fixed read latency, and flags a stall timeout.
module nios_sysid_read_engine
   import nios_sysid_pkg::*;
#(
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    go,
   input  logic                    addr,
   output logic [SYSID_DATA_W-1:0] rdata,
   output logic                    valid,
   output logic                    tmo,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [SYSID_DATA_W-1:0] avm_readdata
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] wcnt;
   logic [1:0]    lat_cnt;
   logic          lat_active;
   logic          accept;

   always_comb begin
      accept = avm_read && !avm_waitrequest;
      tmo    = (TIMEOUT_CYCLES != 0) && avm_read && avm_waitrequest &&
               (wcnt == TW'(TIMEOUT_CYCLES - 1));
      valid  = (READ_LATENCY == 0) ? accept :
               (lat_active && (lat_cnt == 2'(READ_LATENCY - 1)));
      rdata  = avm_readdata;
   end

   // go takes priority so a back-to-back read keeps avm_read asserted across the accepting edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_read    <= 1'b0;
         avm_address <= SYSID_ID_OFFSET;
         wcnt        <= '0;
         lat_cnt     <= '0;
         lat_active  <= 1'b0;
      end else if (go) begin
         avm_read    <= 1'b1;
         avm_address <= addr;
         wcnt        <= '0;
         lat_active  <= 1'b0;
      end else begin
         if (tmo) begin
            avm_read <= 1'b0;
            wcnt     <= '0;
         end else if (accept) begin
            avm_read <= 1'b0;
            wcnt     <= '0;
            if (READ_LATENCY != 0) begin
               lat_active <= 1'b1;
               lat_cnt    <= '0;
            end
         end else if (avm_read && avm_waitrequest) begin
            wcnt <= wcnt + 1'b1;
         end
         if (lat_active) begin
            if (lat_cnt == 2'(READ_LATENCY - 1))
               lat_active <= 1'b0;
            else
               lat_cnt <= lat_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/nios_sysid_checker.sv
// Reads the sysid ID and timestamp words after reset or on request and
// reports match, mismatch or timeout status to board logic.
module nios_sysid_checker
   import nios_sysid_pkg::*;
#(
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
   parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1624360340,
   parameter int unsigned             READ_LATENCY       = 0,
   parameter int unsigned             TIMEOUT_CYCLES     = 255,
   parameter int unsigned             AUTO_START         = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   output logic                    avm_address,
   output logic                    avm_read,
   input  logic                    avm_waitrequest,
   input  logic [SYSID_DATA_W-1:0] avm_readdata,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    id_mismatch,
   output logic                    ts_mismatch,
   output logic                    timeout,
   output logic [SYSID_DATA_W-1:0] id_value,
   output logic [SYSID_DATA_W-1:0] ts_value
);

   sysid_state_t            state, next_state;
   logic                    go, rd_addr, valid, tmo, accept, clear, auto_pend;
   logic [SYSID_DATA_W-1:0] rdata;

   nios_sysid_read_engine #(
      .READ_LATENCY  (READ_LATENCY),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_engine (
      .clock          (clock),
      .reset_n        (reset_n),
      .go             (go),
      .addr           (rd_addr),
      .rdata          (rdata),
      .valid          (valid),
      .tmo            (tmo),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      accept     = avm_read && !avm_waitrequest;
      next_state = state;
      unique case (state)
         IDLE:   if (start || auto_pend) next_state = RD_ID;
         RD_ID:  if (tmo) next_state = FIN;
                 else if (valid) next_state = RD_TS;
                 else if (accept) next_state = LAT_ID;
         LAT_ID: if (valid) next_state = RD_TS;
         RD_TS:  if (tmo || valid) next_state = FIN;
                 else if (accept) next_state = LAT_TS;
         LAT_TS: if (valid) next_state = FIN;
         FIN:    if (start) next_state = RD_ID;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      go      = 1'b0;
      rd_addr = SYSID_ID_OFFSET;
      clear   = 1'b0;
      unique case (state)
         IDLE: begin
            go    = start || auto_pend;
            clear = start || auto_pend;
         end
         FIN: begin
            go    = start;
            clear = start;
         end
         RD_ID, LAT_ID: begin
            go      = valid;
            rd_addr = SYSID_TS_OFFSET;
         end
         default: ;
      endcase
      busy = (state != IDLE) && (state != FIN);
      done = (state == FIN);
      pass = done && !timeout && !id_mismatch && !ts_mismatch;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         auto_pend   <= (AUTO_START != 0);
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         if (clear) begin
            auto_pend   <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
         end
         if (tmo) timeout <= 1'b1;
         if (valid && (state == RD_ID || state == LAT_ID)) begin
            id_value    <= rdata;
            id_mismatch <= (rdata != EXPECTED_ID);
         end
         if (valid && (state == RD_TS || state == LAT_TS)) begin
            ts_value    <= rdata;
            ts_mismatch <= (rdata != EXPECTED_TIMESTAMP);
         end
      end
   end

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Directed bench: u0 is the zero-latency checker with a short stall timeout,
// u_lat uses a two-cycle read latency against a slave that presents data only in its slot.
module tb_nios_sysid_checker;

   localparam logic [31:0] TS = 32'd1624360340;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] id_word = 32'd0;
   logic [31:0] ts_word = TS;
   int          total = 0;
   int          bad = 0;

   logic        a0, r0, wr0, busy0, done0, pass0, idm0, tsm0, tmo0;
   logic [31:0] rd0, idv0, tsv0;
   logic        al, rl, wrl, busyl, donel, passl, idml, tsml, tmol;
   logic [31:0] rdl, idvl, tsvl;
   logic [1:0]  lpend;
   logic        laddr_q;

   always #5 clock = ~clock;

   assign rd0 = a0 ? ts_word : id_word;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lpend   <= 2'd0;
         laddr_q <= 1'b0;
      end else if (rl && !wrl) begin
         lpend   <= 2'd2;
         laddr_q <= al;
      end else if (lpend != 2'd0) begin
         lpend <= lpend - 2'd1;
      end
   end
   assign rdl = (lpend == 2'd1) ? (laddr_q ? ts_word : id_word) : 32'hBAD0BAD0;

   nios_sysid_checker #(
      .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS),
      .READ_LATENCY(0), .TIMEOUT_CYCLES(8), .AUTO_START(1)
   ) u0 (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(a0), .avm_read(r0), .avm_waitrequest(wr0), .avm_readdata(rd0),
      .busy(busy0), .done(done0), .pass(pass0), .id_mismatch(idm0),
      .ts_mismatch(tsm0), .timeout(tmo0), .id_value(idv0), .ts_value(tsv0)
   );

   nios_sysid_checker #(
      .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS),
      .READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1)
   ) u_lat (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(al), .avm_read(rl), .avm_waitrequest(wrl), .avm_readdata(rdl),
      .busy(busyl), .done(donel), .pass(passl), .id_mismatch(idml),
      .ts_mismatch(tsml), .timeout(tmol), .id_value(idvl), .ts_value(tsvl)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      wr0 = 1'b0; wrl = 1'b0; reset_n = 1'b0;
      tick(3);
      total++; if ({r0, a0, busy0, done0, pass0, idm0, tsm0, tmo0} !== 8'h00) begin bad++; $display("FAIL reset_u0_ctl got=%b exp=00000000", {r0, a0, busy0, done0, pass0, idm0, tsm0, tmo0}); end
      total++; if ({idv0, tsv0} !== 64'h0) begin bad++; $display("FAIL reset_u0_val got=%h exp=0", {idv0, tsv0}); end
      total++; if ({rl, al, busyl, donel, passl, idml, tsml, tmol} !== 8'h00) begin bad++; $display("FAIL reset_ulat_ctl got=%b exp=00000000", {rl, al, busyl, donel, passl, idml, tsml, tmol}); end
   endtask

   task automatic test_auto_check();
      reset_n = 1'b1;
      tick();
      total++; if ({r0, a0, busy0, done0} !== 4'b1010) begin bad++; $display("FAIL auto_e1 got=%b exp=1010", {r0, a0, busy0, done0}); end
      tick();
      total++; if ({r0, a0, done0} !== 3'b110) begin bad++; $display("FAIL auto_e2 got=%b exp=110", {r0, a0, done0}); end
      total++; if (idv0 !== 32'd0) begin bad++; $display("FAIL auto_id got=%h exp=0", idv0); end
      tick();
      total++; if ({r0, busy0, done0, pass0} !== 4'b0011) begin bad++; $display("FAIL auto_e3 got=%b exp=0011", {r0, busy0, done0, pass0}); end
      total++; if (tsv0 !== TS) begin bad++; $display("FAIL auto_ts got=%0d exp=%0d", tsv0, TS); end
      tick(5);
      total++; if ({donel, passl} !== 2'b11 || tsvl !== TS) begin bad++; $display("FAIL auto_lat got=%b/%0d exp=11/%0d", {donel, passl}, tsvl, TS); end
   endtask

   task automatic test_id_mismatch();
      id_word = 32'h1;
      pulse_start();
      total++; if ({busy0, done0, pass0} !== 3'b100) begin bad++; $display("FAIL idmm_start got=%b exp=100", {busy0, done0, pass0}); end
      tick(2);
      total++; if ({done0, idm0, tsm0, pass0} !== 4'b1100) begin bad++; $display("FAIL idmm_flags got=%b exp=1100", {done0, idm0, tsm0, pass0}); end
      total++; if (idv0 !== 32'h1) begin bad++; $display("FAIL idmm_val got=%h exp=1", idv0); end
      id_word = 32'd0;
      tick(6);
   endtask

   task automatic test_stall_latency();
      wrl = 1'b1;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         total++; if ({rl, al} !== 2'b10) begin bad++; $display("FAIL stall_hold%0d got=%b exp=10", i, {rl, al}); end
         if (i < 5) tick();
      end
      wrl = 1'b0;
      tick();
      total++; if ({rl, busyl} !== 2'b01) begin bad++; $display("FAIL lat_read_low got=%b exp=01", {rl, busyl}); end
      tick(4);
      total++; if (donel !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", donel); end
      tick();
      total++; if ({donel, passl} !== 2'b11) begin bad++; $display("FAIL lat_done got=%b exp=11", {donel, passl}); end
      total++; if (idvl !== 32'd0 || tsvl !== TS) begin bad++; $display("FAIL lat_vals got=%h/%0d exp=0/%0d", idvl, tsvl, TS); end
   endtask

   task automatic test_timeout();
      wr0 = 1'b1;
      pulse_start();
      tick(7);
      total++; if ({r0, tmo0, done0} !== 3'b100) begin bad++; $display("FAIL tmo_pre got=%b exp=100", {r0, tmo0, done0}); end
      tick();
      total++; if ({r0, tmo0, done0, pass0, busy0} !== 5'b01100) begin bad++; $display("FAIL tmo_flags got=%b exp=01100", {r0, tmo0, done0, pass0, busy0}); end
      total++; if (tsv0 !== 32'd0 || idv0 !== 32'd0) begin bad++; $display("FAIL tmo_vals got=%h/%h exp=0/0", idv0, tsv0); end
      wr0 = 1'b0;
      tick(2);
   endtask

   task automatic test_back_to_back();
      pulse_start();
      tick();
      wr0 = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      total++; if ({r0, a0, busy0, done0} !== 4'b1110) begin bad++; $display("FAIL ign_state got=%b exp=1110", {r0, a0, busy0, done0}); end
      wr0 = 1'b0;
      tick();
      total++; if ({done0, pass0, tmo0} !== 3'b110) begin bad++; $display("FAIL ign_done got=%b exp=110", {done0, pass0, tmo0}); end
      tick(4);
      id_word = 32'h1;
      pulse_start();
      total++; if ({done0, pass0, busy0, tmo0} !== 4'b0010 || tsv0 !== 32'd0) begin bad++; $display("FAIL rerun_clear got=%b/%h exp=0010/0", {done0, pass0, busy0, tmo0}, tsv0); end
      tick(2);
      total++; if ({done0, idm0, pass0} !== 3'b110 || tsv0 !== TS) begin bad++; $display("FAIL rerun_done got=%b/%0d exp=110/%0d", {done0, idm0, pass0}, tsv0, TS); end
      id_word = 32'd0;
      tick(6);
   endtask

   task automatic test_reset_midread();
      wr0 = 1'b1;
      pulse_start();
      tick();
      total++; if (r0 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", r0); end
      reset_n = 1'b0;
      #1;
      total++; if ({r0, a0, busy0, done0, pass0, idm0, tsm0, tmo0} !== 8'h00 || {idv0, tsv0} !== 64'h0) begin bad++; $display("FAIL mid_async got=%b/%h exp=0/0", {r0, a0, busy0, done0, pass0, idm0, tsm0, tmo0}, {idv0, tsv0}); end
      total++; if (rl !== 1'b0) begin bad++; $display("FAIL mid_lat got=%b exp=0", rl); end
      wr0 = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      total++; if ({r0, a0, busy0} !== 3'b101) begin bad++; $display("FAIL mid_rerun got=%b exp=101", {r0, a0, busy0}); end
      tick(2);
      total++; if ({done0, pass0} !== 2'b11) begin bad++; $display("FAIL mid_done got=%b exp=11", {done0, pass0}); end
   endtask

   initial begin
      test_reset();
      test_auto_check();
      test_id_mismatch();
      test_stall_latency();
      test_timeout();
      test_back_to_back();
      test_reset_midread();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
